// File: rtl/gcd_scheduler_if.sv
// Client and engine side signals of gcd_scheduler; the scheduler binds the
// slave modport, client logic plus the GCD engine bind the master modport.
interface gcd_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) ();
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] op_x;
  logic [NUM_REQ*DATA_W-1:0] op_y;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;
  logic                      busy;
  logic                      eng_start;
  logic [DATA_W-1:0]         eng_x;
  logic [DATA_W-1:0]         eng_y;
  logic                      eng_done;
  logic [DATA_W-1:0]         eng_result;
  logic                      eng_abort;

  modport slave (
    input  req, op_x, op_y, eng_done, eng_result,
    output rsp_valid, rsp_data, rsp_err, busy, eng_start, eng_x, eng_y, eng_abort
  );

  modport master (
    output req, op_x, op_y, eng_done, eng_result,
    input  rsp_valid, rsp_data, rsp_err, busy, eng_start, eng_x, eng_y, eng_abort
  );
endinterface

// File: rtl/gcd_scheduler.sv
// Round-robin arbiter sharing one subtract-based GCD engine between NUM_REQ clients.
// Optional WAIT watchdog with engine abort is enabled by defining GCD_SCHED_TIMEOUT_EN.
module gcd_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic            clk,
  input  logic            reset,
  gcd_scheduler_if.slave  bus
);
  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       rr_q, rr_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                busy_q, busy_d;
  logic                eng_start_q, eng_start_d;
  logic [DATA_W-1:0]   eng_x_q, eng_x_d;
  logic [DATA_W-1:0]   eng_y_q, eng_y_d;

  logic [DATA_W-1:0]   op_x_arr [NUM_REQ];
  logic [DATA_W-1:0]   op_y_arr [NUM_REQ];
  logic [NUM_REQ-1:0]  grant_onehot;
  logic                found;
  logic [GW-1:0]       pick;
  logic [GW:0]         sum;
  logic [GW-1:0]       cand;

`ifdef GCD_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rsp_err_q, rsp_err_d;
  logic                eng_abort_q, eng_abort_d;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign op_x_arr[gi] = bus.op_x[gi*DATA_W +: DATA_W];
      assign op_y_arr[gi] = bus.op_y[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign grant_onehot = NUM_REQ'(1) << grant_q;

  // First requesting index at or above rr_q, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_q} + (GW+1)'(k);
      if (sum >= (GW+1)'(NUM_REQ)) begin
        sum = sum - (GW+1)'(NUM_REQ);
      end
      cand = sum[GW-1:0];
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    grant_d     = grant_q;
    eng_x_d     = eng_x_q;
    eng_y_d     = eng_y_q;
    rsp_valid_d = '0;
    rsp_data_d  = '0;
    eng_start_d = 1'b0;
`ifdef GCD_SCHED_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_err_d   = 1'b0;
    eng_abort_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          eng_x_d = op_x_arr[pick];
          eng_y_d = op_y_arr[pick];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // A zero operand would spin the subtract loop forever, so answer locally.
        if (eng_x_q == '0 || eng_y_q == '0) begin
          rsp_valid_d = grant_onehot;
          rsp_data_d  = (eng_x_q == '0) ? eng_y_q : eng_x_q;
          state_d     = RESP;
        end else begin
          eng_start_d = 1'b1;
          state_d     = WAIT;
`ifdef GCD_SCHED_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      WAIT: begin
        // eng_done in the start cycle still belongs to the previous job.
        if (bus.eng_done && !eng_start_q) begin
          rsp_valid_d = grant_onehot;
          rsp_data_d  = bus.eng_result;
          state_d     = RESP;
        end
`ifdef GCD_SCHED_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_valid_d = grant_onehot;
          rsp_err_d   = 1'b1;
          eng_abort_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP: begin
        rr_d    = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      grant_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      eng_start_q <= 1'b0;
      eng_x_q     <= '0;
      eng_y_q     <= '0;
`ifdef GCD_SCHED_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
      eng_abort_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
      eng_start_q <= eng_start_d;
      eng_x_q     <= eng_x_d;
      eng_y_q     <= eng_y_d;
`ifdef GCD_SCHED_TIMEOUT_EN
      cnt_q       <= cnt_d;
      rsp_err_q   <= rsp_err_d;
      eng_abort_q <= eng_abort_d;
`endif
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = busy_q;
  assign bus.eng_start = eng_start_q;
  assign bus.eng_x     = eng_x_q;
  assign bus.eng_y     = eng_y_q;

`ifdef GCD_SCHED_TIMEOUT_EN
  assign bus.rsp_err   = rsp_err_q;
  assign bus.eng_abort = eng_abort_q;
`else
  logic unused_cfg;
  assign unused_cfg    = ^TIMEOUT_CYCLES;
  assign bus.rsp_err   = 1'b0;
  assign bus.eng_abort = 1'b0;
`endif
endmodule

// File: tb/tb_gcd_scheduler.sv
// Self-checking bench for gcd_scheduler: vector table, hand sequences for
// multi-cycle corners, and randomized round-robin traffic against a reference.
module tb_gcd_scheduler;
  localparam int N = 4;
  localparam int W = 8;
`ifdef GCD_SCHED_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1023;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  gcd_scheduler_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

  gcd_scheduler #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [N-1:0]   req_r  = '0;
  logic [N*W-1:0] opx_r  = '0;
  logic [N*W-1:0] opy_r  = '0;
  assign bus.req  = req_r;
  assign bus.op_x = opx_r;
  assign bus.op_y = opy_r;

  int tests = 0;
  int fails = 0;

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    int x, y, t;
    x = int'(a);
    y = int'(b);
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return W'(x);
  endfunction

  // Engine model: 0 = random latency 1..6, >0 fixed latency, <0 never completes.
  int             eng_lat_cfg = 0;
  int             eng_cnt     = 0;
  logic           eng_done_r  = 1'b0;
  logic [W-1:0]   eng_res_r   = '0;
  assign bus.eng_done   = eng_done_r;
  assign bus.eng_result = eng_res_r;

  always @(posedge clk) begin
    if (reset || bus.eng_abort) begin
      eng_done_r <= 1'b0;
      eng_cnt    <= 0;
    end else if (bus.eng_start) begin
      eng_done_r <= 1'b0;
      eng_res_r  <= gcd_ref(bus.eng_x, bus.eng_y);
      if (eng_lat_cfg < 0)      eng_cnt <= 0;
      else if (eng_lat_cfg > 0) eng_cnt <= eng_lat_cfg;
      else                      eng_cnt <= int'($urandom_range(1, 6));
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) eng_done_r <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end else begin
      $display("[TB] ok   %s = %0d", name, act);
    end
  endtask

  // Waits (bounded) for a response pulse; also records eng_start pulses seen on the way.
  task automatic wait_rsp(input int maxc, output logic [N-1:0] v, output logic [W-1:0] d,
                          output logic e, output int ncyc, output int starts,
                          output logic [W-1:0] sx, output logic [W-1:0] sy);
    v = '0; d = '0; e = 1'b0; ncyc = 0; starts = 0; sx = '0; sy = '0;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      ncyc++;
      if (bus.eng_start) begin
        starts++;
        sx = bus.eng_x;
        sy = bus.eng_y;
      end
      if (bus.rsp_valid != '0) begin
        v = bus.rsp_valid;
        d = bus.rsp_data;
        e = bus.rsp_err;
        break;
      end
    end
  endtask

  task automatic set_ops(input int idx, input logic [W-1:0] x, input logic [W-1:0] y);
    opx_r[idx*W +: W] = x;
    opy_r[idx*W +: W] = y;
  endtask

  function automatic logic [31:0] out_vec();
    return {bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.busy, bus.eng_start,
            bus.eng_x, bus.eng_y, bus.eng_abort};
  endfunction

  typedef struct {
    int           idx;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [N-1:0] exp_v;
    logic [W-1:0] exp_d;
    int           exp_starts;
  } vec_t;

  vec_t vecs [8];

  logic [N-1:0] v;
  logic [W-1:0] d, sx, sy;
  logic         e;
  int           ncyc, starts, ptr, g, k;
  logic [N-1:0] pending;
  logic [W-1:0] rx [N];
  logic [W-1:0] ry [N];
  int           fair_g [6];
  logic [W-1:0] fair_d [6];

  initial begin
    vecs[0] = '{0, 8'd48,  8'd18,  4'b0001, 8'd6,   1};
    vecs[1] = '{1, 8'd0,   8'd35,  4'b0010, 8'd35,  0};
    vecs[2] = '{1, 8'd0,   8'd0,   4'b0010, 8'd0,   0};
    vecs[3] = '{3, 8'd35,  8'd0,   4'b1000, 8'd35,  0};
    vecs[4] = '{2, 8'd21,  8'd14,  4'b0100, 8'd7,   1};
    vecs[5] = '{0, 8'd255, 8'd255, 4'b0001, 8'd255, 1};
    vecs[6] = '{1, 8'd200, 8'd150, 4'b0010, 8'd50,  1};
    vecs[7] = '{3, 8'd1,   8'd200, 4'b1000, 8'd1,   1};
    fair_g = '{0, 1, 2, 3, 0, 1};
    fair_d = '{8'd4, 8'd3, 8'd7, 8'd25, 8'd4, 8'd3};

    repeat (3) @(negedge clk);
    check("reset_outputs", out_vec(), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_outputs", out_vec(), 32'd0);

    // Isolated jobs from the vector table.
    for (int i = 0; i < 8; i++) begin
      set_ops(vecs[i].idx, vecs[i].x, vecs[i].y);
      req_r[vecs[i].idx] = 1'b1;
      wait_rsp(100, v, d, e, ncyc, starts, sx, sy);
      req_r[vecs[i].idx] = 1'b0;
      check($sformatf("vec%0d_rsp_valid", i), 32'(v), 32'(vecs[i].exp_v));
      check($sformatf("vec%0d_rsp_data", i), 32'(d), 32'(vecs[i].exp_d));
      check($sformatf("vec%0d_rsp_err", i), 32'(e), 32'd0);
      check($sformatf("vec%0d_eng_starts", i), 32'(starts), 32'(vecs[i].exp_starts));
      if (vecs[i].exp_starts == 0) begin
        // req cycle counts as cycle 1; bypass response lands in cycle 3
        check($sformatf("vec%0d_bypass_latency", i), 32'(ncyc + 1), 32'd3);
      end else begin
        check($sformatf("vec%0d_eng_operands", i), {16'd0, sx, sy}, {16'd0, vecs[i].x, vecs[i].y});
      end
      @(negedge clk);
      check($sformatf("vec%0d_busy_after", i), 32'(bus.busy), 32'd0);
    end

    // Fairness: all four held, pointer starts at 0 after the table.
    set_ops(0, 8'd12, 8'd8);
    set_ops(1, 8'd9, 8'd6);
    set_ops(2, 8'd7, 8'd7);
    set_ops(3, 8'd100, 8'd75);
    req_r = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      wait_rsp(100, v, d, e, ncyc, starts, sx, sy);
      if (i == 5) req_r = '0;
      check($sformatf("fair%0d_grant", i), 32'(v), 32'(4'b0001 << fair_g[i]));
      check($sformatf("fair%0d_data", i), 32'(d), 32'(fair_d[i]));
    end
    repeat (2) @(negedge clk);

    // Operand change and req drop after grant (pointer now at 2).
    set_ops(2, 8'd21, 8'd14);
    req_r[2] = 1'b1;
    k = 0;
    while (!bus.eng_start && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("opchg_start_seen", 32'(bus.eng_start), 32'd1);
    @(negedge clk);
    opx_r[2*W +: W] = 8'd99;
    req_r[2] = 1'b0;
    wait_rsp(100, v, d, e, ncyc, starts, sx, sy);
    check("opchg_rsp_valid", 32'(v), 32'b0100);
    check("opchg_rsp_data", 32'(d), 32'd7);
    repeat (2) @(negedge clk);

    // Reset while the engine is busy; pointer is at 3 beforehand.
    eng_lat_cfg = -1;
    set_ops(3, 8'd200, 8'd1);
    req_r[3] = 1'b1;
    k = 0;
    while (!bus.eng_start && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    reset = 1'b1;
    req_r = '0;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_outputs", out_vec(), 32'd0);
    eng_lat_cfg = 0;
    v = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      v = v | bus.rsp_valid;
    end
    check("midreset_no_rsp", 32'(v), 32'd0);
    set_ops(0, 8'd30, 8'd12);
    set_ops(3, 8'd0, 8'd9);
    req_r = 4'b1001;
    wait_rsp(100, v, d, e, ncyc, starts, sx, sy);
    req_r[0] = 1'b0;
    check("postreset_grant0", 32'(v), 32'b0001);
    check("postreset_data0", 32'(d), 32'd6);
    wait_rsp(100, v, d, e, ncyc, starts, sx, sy);
    req_r[3] = 1'b0;
    check("postreset_grant3", 32'(v), 32'b1000);
    check("postreset_data3", 32'(d), 32'd9);
    repeat (2) @(negedge clk);
    ptr = 0;

`ifdef GCD_SCHED_TIMEOUT_EN
    eng_lat_cfg = -1;
    set_ops(0, 8'd48, 8'd18);
    req_r[0] = 1'b1;
    k = 0;
    while (!bus.eng_start && k < 20) begin
      @(negedge clk);
      k++;
    end
    k = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      k++;
      if (bus.eng_abort) break;
    end
    req_r[0] = 1'b0;
    check("timeout_abort_delay", 32'(k), 32'd16);
    check("timeout_rsp_valid", 32'(bus.rsp_valid), 32'b0001);
    check("timeout_rsp_err", 32'(bus.rsp_err), 32'd1);
    check("timeout_rsp_data", 32'(bus.rsp_data), 32'd0);
    repeat (2) @(negedge clk);
    eng_lat_cfg = 14;
    req_r[0] = 1'b1;
    wait_rsp(100, v, d, e, ncyc, starts, sx, sy);
    req_r[0] = 1'b0;
    check("expiry_done_err", 32'(e), 32'd0);
    check("expiry_done_data", 32'(d), 32'd6);
    check("expiry_no_abort", 32'(bus.eng_abort), 32'd0);
    eng_lat_cfg = 0;
    repeat (2) @(negedge clk);
    ptr = 1;
`endif

    // Randomized rounds: a set of requesters held until each is served.
    for (int r = 0; r < 30; r++) begin
      pending = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        rx[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : W'($urandom_range(1, 255));
        ry[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : W'($urandom_range(1, 255));
        set_ops(i, rx[i], ry[i]);
      end
      req_r = pending;
      while (pending != '0) begin
        g = -1;
        for (int s = 0; s < N; s++) begin
          if (g < 0 && pending[(ptr + s) % N]) g = (ptr + s) % N;
        end
        wait_rsp(200, v, d, e, ncyc, starts, sx, sy);
        check($sformatf("rand%0d_grant", r), 32'(v), 32'(4'b0001 << g));
        check($sformatf("rand%0d_data", r), 32'(d), 32'(gcd_ref(rx[g], ry[g])));
        if (v == '0) begin
          pending = '0;
        end else begin
          req_r[g]   = 1'b0;
          pending[g] = 1'b0;
        end
        ptr = (g + 1) % N;
      end
      req_r = '0;
      repeat (2) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
